// File: rtl/msk_shares_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------------------------+
// | Module   : msk_shares_deserializer                                                         |
// | Purpose  : packs a 32-bit word stream into one 128*D-bit share-sequential block for the    |
// |            masked AES top. Optional second holding register: MSK_DESER_DOUBLE_BUFFER_EN.   |
// | Revision : 1.0  initial release                                                            |
// +--------------------------------------------------------------------------------------------+
module msk_shares_deserializer #(
  parameter int D = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [128*D-1:0]  out_shares_data,
  output logic              busy
);

  localparam int                 c_words = 4 * D;
  localparam int                 c_cnt_w = $clog2(c_words);
  localparam int                 c_bits  = 128 * D;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(c_words - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic [c_bits-1:0]  r_fill;
  logic               r_in_ready;
  logic               w_xfer;
  logic               w_last;

  // rst and clear block the handshake in the very cycle they are asserted
  assign in_ready = r_in_ready & ~rst & ~clear;
  assign w_xfer   = in_valid & in_ready;
  assign w_last   = w_xfer & (r_cnt == c_last);
  assign busy     = (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (w_xfer) begin
      r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + c_cnt_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= '0;
    end else if (w_xfer) begin
      for (int i = 0; i < c_words; i++) begin
        if (r_cnt == c_cnt_w'(i)) begin
          r_fill[32*i +: 32] <= in_data;
        end
      end
    end
  end

`ifdef MSK_DESER_DOUBLE_BUFFER_EN
  logic [c_bits-1:0] r_hold;
  logic              r_hold_valid;
  logic              r_fill_full;
  logic              w_move;
  logic              w_hold_valid_next;
  logic              w_fill_full_next;
  logic [c_bits-1:0] w_fill_next;

  // completed block including the word arriving this cycle (last slot is the top word)
  assign w_fill_next = {in_data, r_fill[c_bits-33:0]};
  assign w_move      = (w_last | r_fill_full) & (~r_hold_valid | out_ready);

  always_comb begin
    w_hold_valid_next = r_hold_valid;
    w_fill_full_next  = r_fill_full;
    if (clear) begin
      w_hold_valid_next = 1'b0;
      w_fill_full_next  = 1'b0;
    end else if (w_move) begin
      w_hold_valid_next = 1'b1;
      w_fill_full_next  = 1'b0;
    end else begin
      if (w_last) begin
        w_fill_full_next = 1'b1;
      end
      if (out_ready) begin
        w_hold_valid_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_fill_full  <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      r_hold_valid <= w_hold_valid_next;
      r_fill_full  <= w_fill_full_next;
      r_in_ready   <= ~(w_fill_full_next & w_hold_valid_next);
      if (w_move && !clear) begin
        r_hold <= r_fill_full ? r_fill : w_fill_next;
      end
    end
  end

  assign out_valid       = r_hold_valid & ~rst;
  assign out_shares_data = r_hold;
`else
  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:  if (w_last)    w_state_next = S_FULL;
      S_FULL:  if (out_ready) w_state_next = S_FILL;
      default:                w_state_next = S_FILL;
    endcase
    if (clear) begin
      w_state_next = S_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FILL;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next == S_FILL);
    end
  end

  assign out_valid       = (r_state == S_FULL) & ~rst;
  assign out_shares_data = r_fill;
`endif

endmodule
`default_nettype wire

// File: tb/tb_msk_shares_deserializer.sv
`timescale 1ns/1ps
`default_nettype none
// Testbench for msk_shares_deserializer: directed and throttled word streams, blocks checked
// against a queue of expected blocks by an independent monitor.
module tb_msk_shares_deserializer;

  localparam int D     = 2;
  localparam int WORDS = 4 * D;
  localparam int BITS  = 128 * D;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [BITS-1:0]  out_shares_data;
  logic             busy;

  always #5 clk = ~clk;

  msk_shares_deserializer #(.D(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .clear           (clear),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_shares_data (out_shares_data),
    .busy            (busy)
  );

  int              n_checks = 0;
  int              n_pass = 0;
  int              blocks_pushed = 0;
  int              blocks_popped = 0;
  int              xfer_cnt = 0;
  bit              rand_ready = 1'b0;
  logic [BITS-1:0] exp_q[$];
  logic [31:0]     part_q[$];

  task automatic report();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  endtask

  task automatic check(input string name, input logic [BITS-1:0] got, input logic [BITS-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // reference model: accepted words collect into a block in arrival order
  task automatic model_accept(input logic [31:0] w);
    logic [BITS-1:0] blk;
    part_q.push_back(w);
    if (part_q.size() == WORDS) begin
      blk = '0;
      for (int i = 0; i < WORDS; i++) blk[32*i +: 32] = part_q[i];
      exp_q.push_back(blk);
      blocks_pushed++;
      part_q.delete();
    end
  endtask

  task automatic model_abort();
    blocks_pushed -= exp_q.size();
    part_q.delete();
    exp_q.delete();
  endtask

  // entered and left at #1 after a rising edge
  task automatic send_word(input logic [31:0] w);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = w;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: word %h never accepted, required acceptance within 200 cycles", w);
      report();
    end
    model_accept(w);
  endtask

  always @(posedge clk) begin
    if (!rst && in_valid && in_ready) xfer_cnt++;
  end

  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // monitor: pops on every accepted block and enforces hold-while-stalled
  logic [BITS-1:0] prev_data;
  bit              prev_stall = 1'b0;
  always @(negedge clk) begin
    if (rst || clear) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", BITS'(out_valid), BITS'(1));
        check("stall_data", out_shares_data, prev_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_block: got %h expected no block", out_shares_data);
        end else begin
          check("block_data", out_shares_data, exp_q.pop_front());
          blocks_popped++;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_shares_data;
    end
  end

  initial begin
    #3_000_000;
    n_checks++;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    report();
  end

  initial begin
    logic [BITS-1:0] t1_exp;
    logic [BITS-1:0] t3_exp;
    int              snap;
    t1_exp = {32'h8, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1};
    t3_exp = {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", BITS'(in_ready), BITS'(0));
    check("rst_out_valid", BITS'(out_valid), BITS'(0));
    check("rst_busy", BITS'(busy), BITS'(0));
    check("rst_data", out_shares_data, '0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", BITS'(in_ready), BITS'(1));

    // back-to-back block, latency and word placement
    out_ready = 1'b1;
    for (int i = 1; i <= WORDS; i++) begin
      send_word(32'(i));
      if (i == WORDS - 1) check("t1_no_early_valid", BITS'(out_valid), BITS'(0));
      if (i == 1) check("t1_busy", BITS'(busy), BITS'(1));
    end
    check("t1_valid_latency", BITS'(out_valid), BITS'(1));
    check("t1_data", out_shares_data, t1_exp);
    check("t1_busy_wrapped", BITS'(busy), BITS'(0));

`ifdef MSK_DESER_DOUBLE_BUFFER_EN
    // continuous streaming: one word per cycle, no input stalls
    @(posedge clk);
    #1;
    snap = blocks_popped;
    begin
      time t0;
      t0 = $time;
      for (int i = 0; i < 4 * WORDS; i++) send_word(32'h300 + 32'(i));
      check("db_cycles", BITS'(($time - t0) / 10), BITS'(4 * WORDS));
    end
    repeat (3) @(posedge clk);
    #1;
    check("db_blocks", BITS'(blocks_popped - snap), BITS'(4));
`else
    // backpressure: full block held, no word consumed
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < WORDS; i++) send_word(32'h100 + 32'(i));
    snap     = xfer_cnt;
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("t2_in_ready_low", BITS'(in_ready), BITS'(0));
      check("t2_out_valid_held", BITS'(out_valid), BITS'(1));
    end
    check("t2_no_consume", BITS'(xfer_cnt), BITS'(snap));
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) send_word(32'h200 + 32'(i));
`endif

    // clear mid-block
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send_word(32'h31 + 32'(i));
    check("t3_busy_partial", BITS'(busy), BITS'(1));
    snap     = xfer_cnt;
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hBAD0_0BAD;
    #1;
    check("t3_clear_in_ready", BITS'(in_ready), BITS'(0));
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    model_abort();
    check("t3_busy_cleared", BITS'(busy), BITS'(0));
    check("t3_clear_no_consume", BITS'(xfer_cnt), BITS'(snap));
    for (int i = 0; i < WORDS; i++) send_word(32'hA0 + 32'(i));
    check("t3_data", out_shares_data, t3_exp);

    // rst mid-block
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) send_word(32'h41 + 32'(i));
    rst = 1'b1;
    #1;
    check("t4_rst_in_ready", BITS'(in_ready), BITS'(0));
    check("t4_rst_out_valid", BITS'(out_valid), BITS'(0));
    @(posedge clk);
    #1;
    check("t4_busy", BITS'(busy), BITS'(0));
    check("t4_data_reset", out_shares_data, '0);
    rst = 1'b0;
    model_abort();
    @(posedge clk);
    #1;
    for (int i = 0; i < WORDS; i++) send_word(32'h50 + 32'(i));

    // throttled random traffic
    rand_ready = 1'b1;
    for (int b = 0; b < 1000; b++) begin
      for (int i = 0; i < WORDS; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        send_word($urandom);
      end
    end
    rand_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_queue_empty", BITS'(exp_q.size()), BITS'(0));
    check("blocks_delivered", BITS'(blocks_popped), BITS'(blocks_pushed));
    report();
  end

endmodule
`default_nettype wire
